iter_arith_unit: RTL

- Parametrised, multi-cycle successor to the combinational 32-bit adder in the datapath.
- Performs ADD/SUB in one cycle and MUL/DIV iteratively (shift-add / restoring), signed or unsigned.
- Produces a HI/LO result pair, as required by the CPU's mult/div instructions.
- Sits beside the ALU in the execute stage and uses a start/busy/done handshake so the control unit can stall.

---
 rtl/iter_arith_if.sv | 41 ++++
 rtl/iter_arith_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_arith_if.sv
// -----------------------------------------------------------------------------
// iter_arith_if
// Request/response bundle between the execute-stage control and the iterative
// arithmetic unit.
//   master : drives start, op, signed_op, a, b; observes busy, done and results
//   slave  : the arithmetic unit itself
// Signals:
//   start        request, sampled only while the unit is idle
//   op           00 ADD, 01 SUB, 10 MUL, 11 DIV
//   signed_op    two's-complement MUL/DIV when 1
//   a, b         operands (A / dividend, B / divisor)
//   busy, done   handshake status (done is a one-cycle pulse)
//   hi, lo       result pair
//   carry, overflow, div_by_zero  result flags
// -----------------------------------------------------------------------------
interface iter_arith_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic             signed_op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             carry;
   logic             overflow;
   logic             div_by_zero;

   modport master (
      output start, op, signed_op, a, b,
      input  busy, done, hi, lo, carry, overflow, div_by_zero
   );

   modport slave (
      input  start, op, signed_op, a, b,
      output busy, done, hi, lo, carry, overflow, div_by_zero
   );
endinterface

// File: rtl/iter_arith_unit.sv
// -----------------------------------------------------------------------------
// iter_arith_unit
// Multi-cycle arithmetic unit for the execute stage. ADD/SUB complete in one
// cycle; MUL (shift-add) and DIV (restoring) iterate once per cycle on operand
// magnitudes and apply sign correction in a final FIX state. Results are held
// in registers and written together with the done pulse.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    iter_arith_if.slave (start/op/signed_op/a/b in; busy/done/hi/lo/
//          carry/overflow/div_by_zero out)
// -----------------------------------------------------------------------------
module iter_arith_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   iter_arith_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [1:0]       OP_ADD = 2'b00;
   localparam logic [1:0]       OP_SUB = 2'b01;
   localparam logic [1:0]       OP_MUL = 2'b10;
   localparam logic [1:0]       OP_DIV = 2'b11;
   localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONES_V = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MIN_V  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
      return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
      return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x,
                                              input logic sgn);
      return (sgn && x[WIDTH-1]) ? neg_w(x) : x;
   endfunction

   state_t             state_r, state_nxt_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [1:0]         op_r;
   logic [WIDTH-1:0]   acc_hi_r;    // MUL: partial product high / DIV: remainder
   logic [WIDTH-1:0]   acc_lo_r;    // MUL: multiplier+product low / DIV: dividend->quotient
   logic [WIDTH-1:0]   dsor_r;      // MUL multiplicand / DIV divisor magnitude
   logic               neg_q_r;     // negate product or quotient in FIX
   logic               neg_r_r;     // negate remainder in FIX
   logic               ovf_pend_r;  // signed MIN / -1 detected at accept
   logic [WIDTH-1:0]   hi_r, lo_r;
   logic               carry_r, ovf_r, dbz_r;
   logic               busy_s, done_s;

   logic [WIDTH:0]     add_s, sub_s;
   logic               add_ovf_s, sub_ovf_s;
   logic [WIDTH-1:0]   mag_a_s, mag_b_s;
   logic               is_min_m1_s;
   logic [WIDTH:0]     mul_sum_s;
   logic [WIDTH:0]     div_shift_s;
   logic [WIDTH-1:0]   div_diff_s;
   logic               div_ge_s;
   logic [WIDTH-1:0]   calc_hi_s, calc_lo_s;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   fix_hi_s, fix_lo_s;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; start is only looked at in IDLE
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               if (bus.op == OP_MUL || (bus.op == OP_DIV && bus.b != ZERO_V)) begin
                  state_nxt_s = ST_CALC;
               end else begin
                  state_nxt_s = ST_DONE;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (cnt_r == CNT_ONE) begin
               state_nxt_s = ST_FIX;
            end else begin
               state_nxt_s = ST_CALC;
            end
         end
         ST_FIX:  state_nxt_s = ST_DONE;
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Handshake outputs decoded from the state register
   always_comb begin
      busy_s = (state_r != ST_IDLE);
      done_s = (state_r == ST_DONE);
   end

   // Single-cycle ADD/SUB results and operand preparation for MUL/DIV
   always_comb begin
      add_s       = {1'b0, bus.a} + {1'b0, bus.b};
      sub_s       = {1'b0, bus.a} - {1'b0, bus.b};
      add_ovf_s   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_s[WIDTH-1] != bus.a[WIDTH-1]);
      sub_ovf_s   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_s[WIDTH-1] != bus.a[WIDTH-1]);
      mag_a_s     = abs_w(bus.a, bus.signed_op);
      mag_b_s     = abs_w(bus.b, bus.signed_op);
      is_min_m1_s = bus.signed_op && (bus.a == MIN_V) && (bus.b == ONES_V);
   end

   // One shift-add or restoring-divide step on the working registers
   always_comb begin
      mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, dsor_r} : {(WIDTH+1){1'b0}});
      div_shift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
      div_ge_s    = (div_shift_s >= {1'b0, dsor_r});
      // When the trial subtraction succeeds the difference is below the divisor,
      // so the low WIDTH bits are exact.
      div_diff_s  = div_shift_s[WIDTH-1:0] - dsor_r;
      if (op_r == OP_MUL) begin
         calc_hi_s = mul_sum_s[WIDTH:1];
         calc_lo_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
      end else if (div_ge_s) begin
         calc_hi_s = div_diff_s;
         calc_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
      end else begin
         calc_hi_s = div_shift_s[WIDTH-1:0];
         calc_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
      end
   end

   // Sign correction of the magnitude result
   always_comb begin
      prod_s = {acc_hi_r, acc_lo_r};
      if (op_r == OP_MUL) begin
         if (neg_q_r) begin
            prod_s = neg_2w({acc_hi_r, acc_lo_r});
         end else begin
            prod_s = {acc_hi_r, acc_lo_r};
         end
         fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
         fix_lo_s = prod_s[WIDTH-1:0];
      end else begin
         fix_lo_s = neg_q_r ? neg_w(acc_lo_r) : acc_lo_r;
         fix_hi_s = neg_r_r ? neg_w(acc_hi_r) : acc_hi_r;
      end
   end

   // Operand capture, iteration and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r      <= {CNT_W{1'b0}};
         op_r       <= 2'b00;
         acc_hi_r   <= ZERO_V;
         acc_lo_r   <= ZERO_V;
         dsor_r     <= ZERO_V;
         neg_q_r    <= 1'b0;
         neg_r_r    <= 1'b0;
         ovf_pend_r <= 1'b0;
         hi_r       <= ZERO_V;
         lo_r       <= ZERO_V;
         carry_r    <= 1'b0;
         ovf_r      <= 1'b0;
         dbz_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  op_r       <= bus.op;
                  acc_hi_r   <= ZERO_V;
                  acc_lo_r   <= mag_a_s;
                  dsor_r     <= mag_b_s;
                  neg_q_r    <= bus.signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  neg_r_r    <= bus.signed_op && bus.a[WIDTH-1];
                  ovf_pend_r <= (bus.op == OP_DIV) && is_min_m1_s;
                  cnt_r      <= CNT_W'(WIDTH);
                  case (bus.op)
                     OP_ADD: begin
                        hi_r    <= ZERO_V;
                        lo_r    <= add_s[WIDTH-1:0];
                        carry_r <= add_s[WIDTH];
                        ovf_r   <= add_ovf_s;
                        dbz_r   <= 1'b0;
                     end
                     OP_SUB: begin
                        hi_r    <= ZERO_V;
                        lo_r    <= sub_s[WIDTH-1:0];
                        carry_r <= sub_s[WIDTH];
                        ovf_r   <= sub_ovf_s;
                        dbz_r   <= 1'b0;
                     end
                     OP_DIV: begin
                        if (bus.b == ZERO_V) begin
                           hi_r    <= bus.a;
                           lo_r    <= ONES_V;
                           carry_r <= 1'b0;
                           ovf_r   <= 1'b0;
                           dbz_r   <= 1'b1;
                        end
                     end
                     default: begin
                     end
                  endcase
               end
            end
            ST_CALC: begin
               acc_hi_r <= calc_hi_s;
               acc_lo_r <= calc_lo_s;
               cnt_r    <= cnt_r - CNT_ONE;
            end
            ST_FIX: begin
               // MIN / -1 falls out of the magnitude path as lo=MIN, hi=0;
               // only the overflow flag needs adding.
               hi_r    <= fix_hi_s;
               lo_r    <= fix_lo_s;
               carry_r <= 1'b0;
               ovf_r   <= ovf_pend_r;
               dbz_r   <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.busy        = busy_s;
   assign bus.done        = done_s;
   assign bus.hi          = hi_r;
   assign bus.lo          = lo_r;
   assign bus.carry       = carry_r;
   assign bus.overflow    = ovf_r;
   assign bus.div_by_zero = dbz_r;

endmodule
